// File: rtl/btn_pkg.sv
// Shared constants for the button front-end: channel count, board button indices, default timings.
// The optional auto-repeat feature in btn_debounce_ch is enabled by defining BTN_AUTOREPEAT_EN.
package btn_pkg;

    localparam int N_BTN = 8;

    localparam int BTN_A = 0;
    localparam int BTN_B = 1;
    localparam int BTN_C = 2;
    localparam int BTN_D = 3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;
    localparam int DEFAULT_REPEAT_DELAY    = 500000;
    localparam int DEFAULT_REPEAT_PERIOD   = 150000;

    // Bits needed to hold values 0..max_val.
    function automatic int bits_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level and press/release pulses.
// BTN_AUTOREPEAT_EN adds a repeat counter that emits extra press pulses while the button is held.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_nxt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             flip;
    logic             rel_nxt;
    logic             rpt_fire;

    assign sync      = ~sync2;
    assign flip      = (sync != lvl) && (cnt == CNT_LAST);
    assign press_nxt = (flip && sync) || rpt_fire;
    assign rel_nxt   = flip && !sync;
    assign level     = lvl;

    // NOTE: every register here uses <=, so all flops sample pre-edge values and the
    // synchroniser really is two stages; a blocking '=' would collapse it into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            if (sync == lvl) begin
                cnt <= '0;
            end else if (flip) begin
                cnt <= '0;
                lvl <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = bits_for((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_last;
    logic             rpt_armed;

    // The first repeat waits REPEAT_DELAY; later ones use REPEAT_PERIOD. No repeat on the release edge.
    assign rpt_last = rpt_armed ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    assign rpt_fire = lvl && !flip && (rpt_cnt == rpt_last);

    always_ff @(posedge clk) begin
        if (rst || !lvl) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Button bank front-end: N_BTN independent debounce channels plus a registered any-press flag.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses on held buttons.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = btn_pkg::N_BTN,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             btn_any
);

    logic [N_BTN-1:0] press_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw_n     (btn_n_raw[i]),
            .level     (btn_level[i]),
            .press     (btn_press[i]),
            .rel       (btn_release[i]),
            .press_nxt (press_nxt[i])
        );
    end

    // Built from the channels' next-state pulses so it lines up with btn_press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_any <= 1'b0;
        end else begin
            btn_any <= |press_nxt;
        end
    end

endmodule
